// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ALU for the ID/EX operand stage.
// The master drives the ID fields and forwarding inputs; the slave is the pipeline stage.
interface id_ex_operand_stage_if #(
  parameter int WORD = 32,
  parameter int REGW = 5
);
  logic            stall;
  logic            flush;

  logic            id_valid;
  logic [WORD-1:0] id_rs_data;
  logic [WORD-1:0] id_rt_data;
  logic [WORD-1:0] id_imm;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic [1:0]      id_alu_op;
  logic [5:0]      id_funct;
  logic            id_alu_src;
  logic            id_reg_dst;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_mem_to_reg;

  logic            exmem_reg_write;
  logic [REGW-1:0] exmem_rd;
  logic [WORD-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [REGW-1:0] memwb_rd;
  logic [WORD-1:0] memwb_result;

  logic [WORD-1:0] alu_a;
  logic [WORD-1:0] alu_b;
  logic [3:0]      alu_control;
  logic [WORD-1:0] ex_store_data;
  logic [REGW-1:0] ex_write_reg;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            load_use_hazard;

  modport master (
    output stall, flush,
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output id_alu_op, id_funct, id_alu_src, id_reg_dst,
    output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output exmem_reg_write, exmem_rd, exmem_result,
    output memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  load_use_hazard
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  id_alu_op, id_funct, id_alu_src, id_reg_dst,
    input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  exmem_reg_write, exmem_rd, exmem_result,
    input  memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register of a 5-stage MIPS pipeline: latches decoded fields, forwards operands
// from EX/MEM and MEM/WB, decodes the ALU control code and detects load-use hazards.
module id_ex_operand_stage #(
  parameter int WORD = 32,
  parameter int REGW = 5
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_operand_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_ctl_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [5:0]      funct;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] write_reg;
    logic [WORD-1:0] rs_data;
    logic [WORD-1:0] rt_data;
    logic [WORD-1:0] imm;
  } stage_t;

  stage_t          ex_q;
  stage_t          id_d;
  logic            load_use;
  logic [WORD-1:0] fwd_rs;
  logic [WORD-1:0] fwd_rt;
  alu_ctl_e        alu_ctl;

  // NOTE: every field gets a default before the selective assignments so no latch is inferred.
  always_comb begin
    id_d            = '0;
    id_d.valid      = bus.id_valid;
    id_d.reg_write  = bus.id_reg_write;
    id_d.mem_read   = bus.id_mem_read;
    id_d.mem_write  = bus.id_mem_write;
    id_d.mem_to_reg = bus.id_mem_to_reg;
    id_d.alu_src    = bus.id_alu_src;
    id_d.alu_op     = bus.id_alu_op;
    id_d.funct      = bus.id_funct;
    id_d.rs         = bus.id_rs;
    id_d.rt         = bus.id_rt;
    id_d.write_reg  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    id_d.rs_data    = bus.id_rs_data;
    id_d.rt_data    = bus.id_rt_data;
    id_d.imm        = bus.id_imm;
  end

  // The load in EX writes rt; a reader in ID must wait one slot for the MEM/WB forward.
  assign load_use = ex_q.valid & ex_q.mem_read & bus.id_valid & (ex_q.rt != '0)
                  & ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

  // NOTE: non-blocking assignments keep every stage register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      ex_q <= '0;
    end else if (!bus.stall) begin
      ex_q <= load_use ? stage_t'('0) : id_d;
    end
  end

  function automatic logic [WORD-1:0] forward(
    input logic [REGW-1:0] idx,
    input logic [WORD-1:0] raw,
    input logic            exmem_we,
    input logic [REGW-1:0] exmem_idx,
    input logic [WORD-1:0] exmem_val,
    input logic            memwb_we,
    input logic [REGW-1:0] memwb_idx,
    input logic [WORD-1:0] memwb_val
  );
    if (exmem_we && (exmem_idx != '0) && (exmem_idx == idx)) begin
      return exmem_val;
    end else if (memwb_we && (memwb_idx != '0) && (memwb_idx == idx)) begin
      return memwb_val;
    end
    return raw;
  endfunction

  always_comb begin
    fwd_rs = forward(ex_q.rs, ex_q.rs_data,
                     bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    fwd_rt = forward(ex_q.rt, ex_q.rt_data,
                     bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                     bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    case (ex_q.alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      2'b11: alu_ctl = ALU_OR;
      default: begin
        case (ex_q.funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_NOP;
        endcase
      end
    endcase
  end

  assign bus.alu_a           = fwd_rs;
  assign bus.alu_b           = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign bus.alu_control     = alu_ctl;
  assign bus.ex_store_data   = fwd_rt;
  assign bus.ex_write_reg    = ex_q.write_reg;
  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_reg_write    = ex_q.reg_write;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.ex_mem_write    = ex_q.mem_write;
  assign bus.ex_mem_to_reg   = ex_q.mem_to_reg;
  assign bus.load_use_hazard = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a per-cycle model comparison plus literal expectations.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.WORD(32), .REGW(5)) bus ();

  id_ex_operand_stage #(.WORD(32), .REGW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what instruction currently occupies EX (a bubble is an all-zero slot).
  typedef struct {
    bit          valid, rw, mr, mw, m2r, alu_src;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, wr;
    logic [31:0] rs_data, rt_data, imm;
  } slot_t;

  slot_t m = '{default: '0};

  function automatic slot_t bubble();
    slot_t s = '{default: '0};
    return s;
  endfunction

  function automatic bit model_hazard(input slot_t s);
    return s.valid && s.mr && bus.id_valid && s.rt != 0 &&
           (s.rt == bus.id_rs || s.rt == bus.id_rt);
  endfunction

  function automatic slot_t from_id();
    slot_t s;
    s.valid = bus.id_valid;  s.rw = bus.id_reg_write;   s.mr = bus.id_mem_read;
    s.mw = bus.id_mem_write; s.m2r = bus.id_mem_to_reg; s.alu_src = bus.id_alu_src;
    s.op = bus.id_alu_op;    s.funct = bus.id_funct;
    s.rs = bus.id_rs;        s.rt = bus.id_rt;
    s.wr = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    s.rs_data = bus.id_rs_data; s.rt_data = bus.id_rt_data; s.imm = bus.id_imm;
    return s;
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] raw);
    if (idx == 0) return raw;
    if (bus.exmem_reg_write && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == idx) return bus.memwb_result;
    return raw;
  endfunction

  function automatic logic [3:0] model_ctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2a:   return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n)               m <= bubble();
    else if (bus.flush)       m <= bubble();
    else if (bus.stall)       m <= m;
    else if (model_hazard(m)) m <= bubble();
    else                      m <= from_id();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ex_valid",   32'(bus.ex_valid),        32'(m.valid));
      check("m_reg_write",  32'(bus.ex_reg_write),    32'(m.rw));
      check("m_mem_read",   32'(bus.ex_mem_read),     32'(m.mr));
      check("m_mem_write",  32'(bus.ex_mem_write),    32'(m.mw));
      check("m_mem_to_reg", 32'(bus.ex_mem_to_reg),   32'(m.m2r));
      check("m_write_reg",  32'(bus.ex_write_reg),    32'(m.wr));
      check("m_alu_a",      bus.alu_a,                model_fwd(m.rs, m.rs_data));
      check("m_alu_b",      bus.alu_b,                m.alu_src ? m.imm : model_fwd(m.rt, m.rt_data));
      check("m_store",      bus.ex_store_data,        model_fwd(m.rt, m.rt_data));
      check("m_alu_ctl",    32'(bus.alu_control),     32'(model_ctl(m.op, m.funct)));
      check("m_hazard",     32'(bus.load_use_hazard), 32'(model_hazard(m)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_alu_op = 0; bus.id_funct = 0; bus.id_alu_src = 0; bus.id_reg_dst = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic load_rtype(input logic [4:0] rs, input logic [31:0] rs_d,
                            input logic [4:0] rt, input logic [31:0] rt_d,
                            input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rd);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rs_data = rs_d; bus.id_rt = rt; bus.id_rt_data = rt_d;
    bus.id_alu_op = op; bus.id_funct = fn; bus.id_reg_dst = 1; bus.id_rd = rd;
    bus.id_reg_write = 1; bus.id_alu_src = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
  endtask

  logic [5:0] fn_tab  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h03};
  logic [3:0] fctl_tab[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
  logic [1:0] op_tab  [3] = '{2'b00, 2'b01, 2'b11};
  logic [3:0] octl_tab[3] = '{4'b0010, 4'b0110, 4'b0001};

  initial begin
    clear_inputs();
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    check("rst_valid", 32'(bus.ex_valid), 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_ctl",   32'(bus.alu_control), 32'h2);
    check("rst_ctrl",  32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}), 0);
    rst_n = 1;

    // R-type sub
    load_rtype(5'd1, 32'd9, 5'd2, 32'd4, 2'b10, 6'b100010, 5'd7);
    tick();
    check("sub_a",   bus.alu_a, 32'd9);
    check("sub_b",   bus.alu_b, 32'd4);
    check("sub_ctl", 32'(bus.alu_control), 32'h6);
    check("sub_wr",  32'(bus.ex_write_reg), 32'd7);
    check("sub_vld", 32'(bus.ex_valid), 1);

    for (int i = 0; i < 6; i++) begin
      bus.id_funct = fn_tab[i];
      tick();
      check("funct_ctl", 32'(bus.alu_control), 32'(fctl_tab[i]));
    end
    for (int i = 0; i < 3; i++) begin
      bus.id_alu_op = op_tab[i];
      bus.id_funct  = 6'h03;
      tick();
      check("op_ctl", 32'(bus.alu_control), 32'(octl_tab[i]));
    end

    // Forwarding priority on latched rs=3, raw data 1
    load_rtype(5'd3, 32'd1, 5'd4, 32'd2, 2'b10, 6'h20, 5'd9);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
    #1 check("fwd_exmem", bus.alu_a, 32'hAA);
    bus.exmem_reg_write = 0;
    #1 check("fwd_memwb", bus.alu_a, 32'hBB);
    bus.exmem_reg_write = 1;
    load_rtype(5'd0, 32'd1, 5'd4, 32'd2, 2'b10, 6'h20, 5'd9);
    tick();
    bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
    #1 check("fwd_r0", bus.alu_a, 32'd1);
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;

    // Load-use: lw writes rt=5, next instruction reads rs=5
    load_rtype(5'd2, 32'h100, 5'd5, 32'd0, 2'b00, 6'h00, 5'd0);
    bus.id_reg_dst = 0; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_alu_src = 1; bus.id_imm = 32'd8;
    tick();
    load_rtype(5'd5, 32'd3, 5'd6, 32'd4, 2'b10, 6'h20, 5'd10);
    #1 check("lu_hazard", 32'(bus.load_use_hazard), 1);
    tick();
    check("lu_bubble", 32'(bus.ex_valid), 0);
    check("lu_clear",  32'(bus.load_use_hazard), 0);
    tick();
    check("lu_reload", 32'(bus.ex_valid), 1);

    // Stall with a pending hazard: held, hazard persists, then one bubble
    load_rtype(5'd2, 32'h100, 5'd5, 32'd0, 2'b00, 6'h00, 5'd0);
    bus.id_reg_dst = 0; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_alu_src = 1; bus.id_imm = 32'd8;
    tick();
    load_rtype(5'd6, 32'd3, 5'd5, 32'd4, 2'b10, 6'h20, 5'd10);
    bus.stall = 1;
    tick();
    tick();
    check("sh_hazard", 32'(bus.load_use_hazard), 1);
    check("sh_hold",   32'(bus.ex_mem_read), 1);
    bus.stall = 0;
    tick();
    check("sh_bubble", 32'(bus.ex_valid), 0);

    // Stall holds for three cycles, then flush beats stall
    load_rtype(5'd10, 32'h11, 5'd11, 32'h22, 2'b01, 6'h00, 5'd12);
    bus.id_reg_dst = 0;
    tick();
    bus.stall = 1;
    bus.id_rs_data = 32'h99; bus.id_rt_data = 32'h98; bus.id_alu_op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_a",   bus.alu_a, 32'h11);
      check("stall_b",   bus.alu_b, 32'h22);
      check("stall_ctl", 32'(bus.alu_control), 32'h6);
      check("stall_wr",  32'(bus.ex_write_reg), 32'd11);
    end
    bus.flush = 1;
    tick();
    check("flush_vld", 32'(bus.ex_valid), 0);
    check("flush_rw",  32'(bus.ex_reg_write), 0);
    bus.flush = 0; bus.stall = 0;

    // Immediate path with rt forwarded from EX/MEM
    load_rtype(5'd1, 32'd7, 5'd8, 32'd1, 2'b00, 6'h00, 5'd0);
    bus.id_alu_src = 1; bus.id_imm = 32'hFFFFFFFC; bus.id_reg_dst = 0;
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'h55;
    #1;
    check("imm_b",     bus.alu_b, 32'hFFFFFFFC);
    check("imm_ctl",   32'(bus.alu_control), 32'h2);
    check("imm_store", bus.ex_store_data, 32'h55);

    // Reset during a stall clears the stage
    bus.stall = 1;
    rst_n = 0;
    tick();
    check("rst_stall_vld", 32'(bus.ex_valid), 0);
    check("rst_stall_rw",  32'(bus.ex_reg_write), 0);
    rst_n = 1; bus.stall = 0;
    clear_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline, feeding the ALU directly.
- Latches decoded ID-stage fields and selects forwarded operands from the EX/MEM and MEM/WB stages.
- Decodes alu_op/funct into the 4-bit ALU control code.
- Detects load-use hazards and inserts bubbles.

Parameters:
- WORD, 32, datapath width.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold stage contents (downstream stall).
- flush  in  1  squash the instruction being loaded (branch/jump redirect).
- id_valid  in  1  ID slot holds a real instruction.
- id_rs_data, id_rt_data  in  WORD  register file read data.
- id_imm  in  WORD  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REGW  register indices.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 or.
- id_funct  in  6  R-type funct field.
- id_alu_src  in  1  1 = immediate feeds operand b.
- id_reg_dst  in  1  1 = rd is the destination, 0 = rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- exmem_reg_write  in  1;  exmem_rd  in  REGW;  exmem_result  in  WORD.
- memwb_reg_write  in  1;  memwb_rd  in  REGW;  memwb_result  in  WORD.
- alu_a, alu_b  out  WORD  ALU operands.
- alu_control  out  4  ALU operation code.
- ex_store_data  out  WORD  forwarded rt value for stores.
- ex_write_reg  out  REGW  destination register.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
- load_use_hazard  out  1  combinational; upstream holds PC and IF/ID when high.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All stage registers clear to 0: ex_valid=0, all control bits 0, ex_write_reg=0.
  - Resulting outputs: alu_a=0, alu_b=0, alu_control=4'b0010.
- Update priority at each posedge, highest first:
  1. reset;
  2. flush: load a bubble;
  3. stall: hold all registers;
  4. load_use_hazard: load a bubble;
  5. otherwise: load the ID fields.
- Bubble:
  - ex_valid=0 and reg_write/mem_read/mem_write/mem_to_reg = 0.
  - Data fields are don't-care; the implementation zeroes them.
- load_use_hazard = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - Combinational from registered state and ID inputs.
  - Exactly one bubble is inserted per load-use hazard, because the hazard clears once the load leaves EX.
- ex_write_reg = registered (reg_dst ? rd : rt).
- Forwarding: combinational, from the registered rs/rt and the current exmem/memwb inputs.
  - fwd_x = exmem_result when exmem_reg_write & exmem_rd != 0 & exmem_rd == x.
  - Otherwise fwd_x = memwb_result when memwb_reg_write & memwb_rd != 0 & memwb_rd == x.
  - Otherwise fwd_x = the latched register data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = fwd_rs.
  - alu_b = alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt, regardless of alu_src.
- alu_control decode from the registered alu_op/funct, combinational:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10 with funct 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Any other funct -> 1111 (ALU returns 0).
- Latency: ID inputs appear on the outputs one cycle after capture.
- Forwarded values track exmem/memwb inputs in the same cycle.
- Simultaneous events:
  - flush+stall: flush wins, the bubble is loaded.
  - stall+hazard: hold, no bubble consumed; the hazard stays asserted.
  - Reset mid-stall clears the stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> ex_valid=0, alu_a=alu_b=0, alu_control=0010, all control bits 0.
- R-type sub: id_rs_data=9, id_rt_data=4, alu_op=10, funct=100010, reg_dst=1, rd=7 -> next cycle alu_a=9, alu_b=4, alu_control=0110, ex_write_reg=7.
- Forwarding priority, with latched rs=3 and raw data 1:
  - exmem_rd=3, exmem_result=0xAA and memwb_rd=3, memwb_result=0xBB -> alu_a=0xAA.
  - Drop exmem_reg_write -> alu_a=0xBB.
  - Repeat with rs=0 and rd=0 -> alu_a=1, no forwarding.
- Load-use: lw writing rt=5 in EX, ID instruction reads rs=5 -> load_use_hazard=1; next cycle ex_valid=0 (bubble) and load_use_hazard=0.
- Stall/flush: stall=1 for 3 cycles -> all outputs constant; flush=1 together with stall=1 -> next cycle ex_valid=0 and ex_reg_write=0.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, alu_op=00, rt forwarded from EX/MEM as 0x55 -> alu_b=0xFFFFFFFC, alu_control=0010, ex_store_data=0x55.
